// File: rtl/expr_scan.sv
// rtl/expr_scan.sv - streaming infix expression recogniser, one ASCII byte per in_vld strobe
// Define EXPR_PAREN_EN to accept nested parentheses; otherwise '(' and ')' are illegal bytes.
module expr_scan #(
  parameter int MAX_DIGITS = 4,
  parameter int DEPTH_W    = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               restart,
  input  logic               in_vld,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   ops
);

  localparam int              DCW  = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0]  DMAX = DCW'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CMAX = '1;

`ifdef EXPR_PAREN_EN
  typedef enum logic [2:0] {S_EMPTY, S_NUM, S_OP, S_LP, S_RP, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_EMPTY, S_NUM, S_OP, S_ERR} state_t;
`endif

  typedef enum logic [2:0] {C_D, C_O, C_L, C_R, C_X} cls_t;

  state_t           state, state_n;
  cls_t             cls;
  logic [DCW-1:0]   dcnt, dcnt_n;
  logic [CNT_W-1:0] ops_q, ops_n;
  logic             after_operand;
  logic             expects_operand;
  logic             at_top;

`ifdef EXPR_PAREN_EN
  localparam logic [DEPTH_W-1:0] PMAX = '1;
  logic [DEPTH_W-1:0] depth_q, depth_n;

  assign after_operand   = (state == S_NUM) || (state == S_RP);
  assign expects_operand = (state == S_EMPTY) || (state == S_OP) || (state == S_LP);
  assign at_top          = (depth_q == '0);
  assign depth           = depth_q;
`else
  assign after_operand   = (state == S_NUM);
  assign expects_operand = (state == S_EMPTY) || (state == S_OP);
  assign at_top          = 1'b1;
  assign depth           = '0;
`endif

  always_comb begin
    cls = C_X;
    case (in)
      8'h2b, 8'h2d, 8'h2a, 8'h2f: cls = C_O;
`ifdef EXPR_PAREN_EN
      8'h28: cls = C_L;
      8'h29: cls = C_R;
`endif
      default: if (in >= 8'h30 && in <= 8'h39) cls = C_D;
    endcase
  end

  // Every path to S_ERR leaves the counters untouched, so they freeze at pre-error values.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    ops_n   = ops_q;
`ifdef EXPR_PAREN_EN
    depth_n = depth_q;
`endif
    if (in_vld && state != S_ERR) begin
      case (cls)
        C_D: begin
          if (state == S_NUM) begin
            if (dcnt < DMAX) dcnt_n = dcnt + 1'b1;
            else             state_n = S_ERR;
          end else if (expects_operand) begin
            state_n = S_NUM;
            dcnt_n  = DCW'(1);
          end else begin
            state_n = S_ERR;
          end
        end
        C_O: begin
          if (after_operand) begin
            state_n = S_OP;
            if (ops_q != CMAX) ops_n = ops_q + 1'b1;
          end else begin
            state_n = S_ERR;
          end
        end
`ifdef EXPR_PAREN_EN
        C_L: begin
          if (expects_operand && depth_q != PMAX) begin
            state_n = S_LP;
            depth_n = depth_q + 1'b1;
          end else begin
            state_n = S_ERR;
          end
        end
        C_R: begin
          if (after_operand && depth_q != '0) begin
            state_n = S_RP;
            depth_n = depth_q - 1'b1;
          end else begin
            state_n = S_ERR;
          end
        end
`endif
        default: state_n = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_EMPTY;
      dcnt  <= '0;
      ops_q <= '0;
    end else if (restart) begin
      state <= S_EMPTY;
      dcnt  <= '0;
      ops_q <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      ops_q <= ops_n;
    end
  end

`ifdef EXPR_PAREN_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       depth_q <= '0;
    else if (restart) depth_q <= '0;
    else              depth_q <= depth_n;
  end
`endif

  assign out = after_operand && at_top;
  assign err = (state == S_ERR);
  assign ops = ops_q;

endmodule

// File: tb/tb_expr_scan.sv
// tb/tb_expr_scan.sv - self-checking bench for expr_scan (table vectors, corner sequences, random vs model)
module tb_expr_scan;
  localparam int MAX_DIGITS = 4;
  localparam int DEPTH_W    = 3;
  localparam int CNT_W      = 8;
`ifdef EXPR_PAREN_EN
  localparam bit PAREN = 1'b1;
`else
  localparam bit PAREN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               clr_n;
  logic               restart;
  logic               in_vld;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   ops;

  expr_scan #(.MAX_DIGITS(MAX_DIGITS), .DEPTH_W(DEPTH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_vld(in_vld), .in(in),
    .out(out), .err(err), .depth(depth), .ops(ops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: token-level view of the prefix (last token kind, digit run, nesting, op count).
  bit  m_bad;
  byte m_prev;   // 0 none, "d" digit, "o" operator, "l" open, "r" close
  int  m_run, m_depth, m_ops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_out();
    return !m_bad && (m_prev == "d" || m_prev == "r") && m_depth == 0;
  endfunction

  task automatic model_clear();
    m_bad = 0; m_prev = 0; m_run = 0; m_depth = 0; m_ops = 0;
  endtask

  task automatic model_byte(input byte c);
    bit operand_ok;
    if (m_bad) return;
    operand_ok = (m_prev == 0 || m_prev == "o" || m_prev == "l");
    if (c >= "0" && c <= "9") begin
      if (m_prev == "d") begin
        if (m_run < MAX_DIGITS) m_run++;
        else m_bad = 1;
      end else if (operand_ok) begin
        m_run = 1; m_prev = "d";
      end else m_bad = 1;
    end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
      if (m_prev == "d" || m_prev == "r") begin
        m_ops = (m_ops < (1 << CNT_W) - 1) ? m_ops + 1 : m_ops;
        m_prev = "o";
      end else m_bad = 1;
    end else if (PAREN && c == "(") begin
      if (operand_ok && m_depth < (1 << DEPTH_W) - 1) begin
        m_depth++; m_prev = "l";
      end else m_bad = 1;
    end else if (PAREN && c == ")") begin
      if ((m_prev == "d" || m_prev == "r") && m_depth > 0) begin
        m_depth--; m_prev = "r";
      end else m_bad = 1;
    end else m_bad = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out"},   32'(out),   32'(m_out()));
    chk({tag, " err"},   32'(err),   32'(m_bad));
    chk({tag, " depth"}, 32'(depth), 32'(m_depth));
    chk({tag, " ops"},   32'(ops),   32'(m_ops));
  endtask

  task automatic step(input bit rs, input bit v, input byte c, input string tag);
    @(negedge clk);
    restart = rs; in_vld = v; in = c;
    @(posedge clk);
    #1;
    restart = 0; in_vld = 0;
    if (rs) model_clear();
    else if (v) model_byte(c);
    check_model(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(0, 1, s[i], tag);
  endtask

  typedef struct {
    string s;
    bit    out;
    bit    err;
    int    ops;
    int    depth;
  } vec_t;
  vec_t vecs[$];

  function automatic byte rand_char();
    int r = $urandom_range(0, 99);
    if (r < 50) return byte'(8'h30 + $urandom_range(0, 9));
    if (r < 75) begin
      case ($urandom_range(0, 3))
        0: return "+";
        1: return "-";
        2: return "*";
        default: return "/";
      endcase
    end
    if (r < 85) return "(";
    if (r < 95) return ")";
    return "a";
  endfunction

  initial begin
    int exp_out1[4];
    int exp_dep3[9];
    clr_n = 0; restart = 0; in_vld = 0; in = 8'h00;
    model_clear();
    #12;
    check_model("reset");
    @(negedge clk) clr_n = 1;

    vecs.push_back('{"12+3",      1, 0, 1, 0});
    vecs.push_back('{"12345",     0, 1, 0, 0});
    vecs.push_back('{"12345+1",   0, 1, 0, 0});
    vecs.push_back('{"1234",      1, 0, 0, 0});
    vecs.push_back('{"+1",        0, 1, 0, 0});
    vecs.push_back('{"1++",       0, 1, 1, 0});
    vecs.push_back('{")",         0, 1, 0, 0});
    vecs.push_back('{"1a",        0, 1, 0, 0});
    vecs.push_back('{"7",         1, 0, 0, 0});
    vecs.push_back('{"1*2/3-4",   1, 0, 3, 0});
    vecs.push_back('{"9+",        0, 0, 1, 0});
    vecs.push_back('{"-5",        0, 1, 0, 0});
`ifdef EXPR_PAREN_EN
    vecs.push_back('{"(1+(2*3))", 1, 0, 2, 0});
    vecs.push_back('{"((1",       0, 0, 0, 2});
    vecs.push_back('{"()",        0, 1, 0, 1});
    vecs.push_back('{"(1)2",      0, 1, 0, 0});
    vecs.push_back('{"((((((((",  0, 1, 0, 7});
    vecs.push_back('{"(((((((1)))))))", 1, 0, 0, 0});
`else
    vecs.push_back('{"(1)",       0, 1, 0, 0});
`endif

    foreach (vecs[k]) begin
      step(1, 0, 8'h00, "vec restart");
      send_str(vecs[k].s, $sformatf("vec%0d byte", k));
      chk($sformatf("vec%0d out", k),   32'(out),   32'(vecs[k].out));
      chk($sformatf("vec%0d err", k),   32'(err),   32'(vecs[k].err));
      chk($sformatf("vec%0d ops", k),   32'(ops),   32'(vecs[k].ops));
      chk($sformatf("vec%0d depth", k), 32'(depth), 32'(vecs[k].depth));
    end

    // "12+3": out after each byte
    exp_out1 = '{1, 1, 0, 1};
    step(1, 0, 8'h00, "t1 restart");
    for (int i = 0; i < 4; i++) begin
      string s = "12+3";
      step(0, 1, s[i], "t1");
      chk($sformatf("t1 out byte%0d", i), 32'(out), 32'(exp_out1[i]));
    end

`ifdef EXPR_PAREN_EN
    exp_dep3 = '{1, 1, 1, 2, 2, 2, 2, 1, 0};
    step(1, 0, 8'h00, "t3 restart");
    for (int i = 0; i < 9; i++) begin
      string s = "(1+(2*3))";
      step(0, 1, s[i], "t3");
      chk($sformatf("t3 depth byte%0d", i), 32'(depth), 32'(exp_dep3[i]));
    end
`endif

    // in_vld low holds state
    step(1, 0, 8'h00, "hold restart");
    send_str("12", "hold");
    step(0, 0, "+", "hold idle");
    chk("hold out", 32'(out), 32'd1);

    // restart beats a simultaneous byte
    send_str("1+2", "rs pre");
    step(1, 1, "9", "rs+vld");
    chk("rs+vld out", 32'(out), 32'd0);
    chk("rs+vld ops", 32'(ops), 32'd0);
    step(0, 1, "+", "rs empty op");
    chk("rs empty op err", 32'(err), 32'd1);

    // async clear between edges
    step(1, 0, 8'h00, "async restart");
    if (PAREN) send_str("(4-", "async pre");
    else send_str("4-", "async pre");
    #2;
    clr_n = 0;
    #1;
    chk("async out", 32'(out), 32'd0);
    chk("async err", 32'(err), 32'd0);
    chk("async depth", 32'(depth), 32'd0);
    chk("async ops", 32'(ops), 32'd0);
    @(negedge clk) clr_n = 1;
    model_clear();

    // ops saturation
    step(1, 0, 8'h00, "sat restart");
    for (int i = 0; i < 256; i++) send_str("1+", "sat");
    chk("sat ops", 32'(ops), 32'd255);
    chk("sat err", 32'(err), 32'd0);
    step(0, 1, "1", "sat tail");
    chk("sat tail out", 32'(out), 32'd1);
    chk("sat tail ops", 32'(ops), 32'd255);

    // random streams against the model
    for (int run = 0; run < 60; run++) begin
      int len = $urandom_range(1, 24);
      step(1, 0, 8'h00, "rnd restart");
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 99);
        if (r < 15) step(0, 0, rand_char(), "rnd idle");
        else if (r < 17) step(1, 1, rand_char(), "rnd rs");
        else step(0, 1, rand_char(), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
